// File: rtl/seq_det_param_if.sv
// seq_det_param_if -- bus bundle between a pattern-detector master and the detector.
//   master : drives pat_load, pat, x_valid, x and cnt_clr; observes y, match_cnt and armed
//   slave  : the detector side (seq_det_param)
//   PAT_W and CNT_W must match the parameters of the attached detector.
interface seq_det_param_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             pat_load;
  logic [PAT_W-1:0] pat;
  logic             x_valid;
  logic             x;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output pat_load, pat, x_valid, x, cnt_clr,
    input  y, match_cnt, armed
  );

  modport slave (
    input  pat_load, pat, x_valid, x, cnt_clr,
    output y, match_cnt, armed
  );
endinterface

// File: rtl/seq_det_param.sv
// seq_det_param -- programmable serial pattern detector with a saturating match counter.
//   Clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, overrides every other input
//   bus  : seq_det_param_if slave modport
//            pat_load/pat  load the target pattern (pat[PAT_W-1] arrives first) and re-arm
//            x_valid/x     qualified serial data
//            cnt_clr       clear the match counter
//            y             one-cycle match pulse, one clock after the completing bit
//            match_cnt     saturating match count
//            armed         high in FILL or RUN
//
// state | meaning
// IDLE  | no pattern loaded since reset; serial data ignored
// FILL  | fewer than PAT_W bits accepted since arm (or since last match, non-overlap)
// RUN   | window full; every accepted bit is a candidate match
module seq_det_param #(
  parameter int PAT_W   = 5,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8
) (
  input logic          Clk,
  input logic          rst,
  seq_det_param_if.slave bus
);

  localparam int                FILL_W  = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [PAT_W-1:0]    win_q, win_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                y_q, y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic [PAT_W-1:0]    win_upd;
  logic [FILL_W-1:0]   fill_inc;
  logic                match;
  logic [CNT_W-1:0]    cnt_base;

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      win_q   <= '0;
      fill_q  <= '0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    win_d    = win_q;
    fill_d   = fill_q;
    y_d      = 1'b0;
    cnt_d    = cnt_q;
    cnt_base = cnt_q;

    // pat_load owns the cycle: a coincident sample is dropped, not shifted in.
    accept   = bus.x_valid && (state_q != ST_IDLE) && !bus.pat_load;
    win_upd  = {win_q[PAT_W-2:0], bus.x};
    // Fill count saturates at PAT_W so RUN can keep reusing the window.
    fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    match    = accept && (win_upd == pat_q) && (fill_inc == FULL);

    if (bus.pat_load) begin
      pat_d   = bus.pat;
      win_d   = '0;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (accept) begin
      win_d = win_upd;
      if (match && !OVERLAP) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FULL) ? ST_RUN : ST_FILL;
      end
    end

    y_d = match;

    // Clear first, then count, so clear+match in one cycle lands on 1.
    if (bus.cnt_clr) begin
      cnt_base = '0;
    end
    cnt_d = cnt_base;
    if (match && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  assign bus.y         = y_q;
  assign bus.match_cnt = cnt_q;
  assign bus.armed     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_det_param.sv
module tb_seq_det_param;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic        pl  = 1'b0;
  logic        xv  = 1'b0;
  logic        xb  = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] pat16 = '0;

  int errors = 0;
  int checks = 0;

  int q_ov[$];
  int q_nov[$];
  int q_gap[$];
  int q_sat[$];

  always #5 Clk = ~Clk;

  seq_det_param_if #(.PAT_W(4), .CNT_W(8)) if_ov  ();
  seq_det_param_if #(.PAT_W(4), .CNT_W(8)) if_nov ();
  seq_det_param_if #(.PAT_W(5), .CNT_W(8)) if_gap ();
  seq_det_param_if #(.PAT_W(2), .CNT_W(2)) if_sat ();

  assign if_ov.pat_load  = pl;
  assign if_ov.pat       = pat16[3:0];
  assign if_ov.x_valid   = xv;
  assign if_ov.x         = xb;
  assign if_ov.cnt_clr   = clr;
  assign if_nov.pat_load = pl;
  assign if_nov.pat      = pat16[3:0];
  assign if_nov.x_valid  = xv;
  assign if_nov.x        = xb;
  assign if_nov.cnt_clr  = clr;
  assign if_gap.pat_load = pl;
  assign if_gap.pat      = pat16[4:0];
  assign if_gap.x_valid  = xv;
  assign if_gap.x        = xb;
  assign if_gap.cnt_clr  = clr;
  assign if_sat.pat_load = pl;
  assign if_sat.pat      = pat16[1:0];
  assign if_sat.x_valid  = xv;
  assign if_sat.x        = xb;
  assign if_sat.cnt_clr  = clr;

  seq_det_param #(.PAT_W(4), .OVERLAP(1'b1), .CNT_W(8)) u_ov  (.Clk(Clk), .rst(rst), .bus(if_ov));
  seq_det_param #(.PAT_W(4), .OVERLAP(1'b0), .CNT_W(8)) u_nov (.Clk(Clk), .rst(rst), .bus(if_nov));
  seq_det_param #(.PAT_W(5), .OVERLAP(1'b1), .CNT_W(8)) u_gap (.Clk(Clk), .rst(rst), .bus(if_gap));
  seq_det_param #(.PAT_W(2), .OVERLAP(1'b1), .CNT_W(2)) u_sat (.Clk(Clk), .rst(rst), .bus(if_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected y for each checked DUT
  // (-1 = not checked), then pop and compare once the edge has produced y.
  task automatic step(input logic p, input logic v, input logic b, input logic c,
                      input int e_ov, input int e_nov, input int e_gap, input int e_sat);
    @(negedge Clk);
    pl  = p;
    xv  = v;
    xb  = b;
    clr = c;
    if (e_ov  >= 0) q_ov.push_back(e_ov);
    if (e_nov >= 0) q_nov.push_back(e_nov);
    if (e_gap >= 0) q_gap.push_back(e_gap);
    if (e_sat >= 0) q_sat.push_back(e_sat);
    @(posedge Clk);
    #1;
    if (q_ov.size()  > 0) chk("y_ov",  32'(if_ov.y),  32'(q_ov.pop_front()));
    if (q_nov.size() > 0) chk("y_nov", 32'(if_nov.y), 32'(q_nov.pop_front()));
    if (q_gap.size() > 0) chk("y_gap", 32'(if_gap.y), 32'(q_gap.pop_front()));
    if (q_sat.size() > 0) chk("y_sat", 32'(if_sat.y), 32'(q_sat.pop_front()));
  endtask

  // Reset with every other control asserted; reset must win.
  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rst_armed_ov",  32'(if_ov.armed),      32'd0);
    chk("rst_armed_nov", 32'(if_nov.armed),     32'd0);
    chk("rst_armed_gap", 32'(if_gap.armed),     32'd0);
    chk("rst_armed_sat", 32'(if_sat.armed),     32'd0);
    chk("rst_cnt_ov",    32'(if_ov.match_cnt),  32'd0);
    chk("rst_cnt_sat",   32'(if_sat.match_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] s_bits;
    logic [7:0] e_ov8;
    logic [7:0] e_nov8;
    logic [5:0] e_rl;
    logic [5:0] s_rl;

    do_reset();

    // IDLE: valid data before any pattern load is ignored.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    chk("idle_armed_ov", 32'(if_ov.armed),     32'd0);
    chk("idle_cnt_sat",  32'(if_sat.match_cnt), 32'd0);

    // Overlap vs non-overlap, pattern 1010.
    pat16 = 16'h000A;
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
    chk("load_armed_ov", 32'(if_ov.armed), 32'd1);
    s_bits = 8'b1010_1010;
    e_ov8  = 8'b0001_0101;
    e_nov8 = 8'b0001_0001;
    for (int i = 7; i >= 0; i--)
      step(1'b0, 1'b1, s_bits[i], 1'b0, int'(e_ov8[i]), int'(e_nov8[i]), -1, -1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1, -1);
    chk("cnt_ov",  32'(if_ov.match_cnt),  32'd3);
    chk("cnt_nov", 32'(if_nov.match_cnt), 32'd2);

    // Reload with a coincident valid 1: that bit must not enter the window.
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, -1, -1, -1);
    s_rl = 6'b010100;
    e_rl = 6'b000010;
    for (int i = 5; i >= 1; i--)
      step(1'b0, 1'b1, s_rl[i], 1'b0, int'(e_rl[i]), -1, -1, -1);
    chk("reload_cnt_ov", 32'(if_ov.match_cnt), 32'd4);

    // Reset after 3 of 4 bits, then reload and supply the last bit.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, -1, -1, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, -1, -1, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, -1, -1, -1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, -1, -1, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, -1, -1, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, -1, -1, -1);
    chk("postrst_cnt_ov", 32'(if_ov.match_cnt), 32'd0);

    // Gap case: pattern 11001 with a 3-cycle x_valid gap after bit 2.
    do_reset();
    pat16 = 16'h0019;
    step(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 0, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, 0, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, 0, -1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 0, -1);
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, -1, 0, -1);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, 1, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 0, -1);
    chk("gap_cnt", 32'(if_gap.match_cnt), 32'd1);

    // Saturation / clear: pattern 11, 2-bit counter.
    do_reset();
    pat16 = 16'h0003;
    step(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1);
    chk("sat_cnt", 32'(if_sat.match_cnt), 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, -1, -1, -1, 1);
    chk("clr_match_cnt", 32'(if_sat.match_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, -1, -1, -1, 0);
    chk("clr_only_cnt", 32'(if_sat.match_cnt), 32'd0);

    // All-zeros pattern on the same DUT.
    pat16 = 16'h0000;
    step(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, -1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, -1, -1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, -1, -1, -1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, -1, -1, -1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, 0);
    chk("zero_pat_cnt", 32'(if_sat.match_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
